// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared control types and defaults for the fetch/redirect sequencer.
package spu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_t;

  localparam int unsigned PC_W_DEFAULT         = 8;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Fetch-PC sequencer: advances one pair per cycle, redirects on taken branches
// and holds flush for a fixed bubble window before resuming at the target.
module branch_redirect_ctrl
  import spu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = PC_W_DEFAULT,
  parameter int unsigned FETCH_STEP   = 2,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] pc_wb,
  output logic [PC_W-1:0] pc_fetch,
  output logic            fetch_valid,
  output logic            slot0_valid,
  output logic            flush,
  output logic            halted
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  ctrl_state_t      state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             odd_q, odd_d;
  logic             fv_q, fv_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      odd_q   <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
      fv_q    <= fv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    odd_d   = odd_q;
    fv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          odd_d   = 1'b0;
          fv_d    = 1'b1;
        end
      end
      RUN: begin
        if (branch_taken) begin
          state_d = REDIRECT;
          pc_d    = {pc_wb[PC_W-1:1], 1'b0};
          odd_d   = pc_wb[0];
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          fv_d = 1'b1;
          // pc_q only advances once its pair was actually fetched; after a
          // stall the held pair is refetched first.
          if (fv_q) begin
            pc_d  = pc_q + PC_W'(FETCH_STEP);
            odd_d = 1'b0;
          end
        end
      end
      REDIRECT: begin
        // Exit directly into the target fetch so no idle gap follows the flush.
        if (cnt_q == '0) begin
          state_d = RUN;
          fv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HALTED: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pc_fetch    = pc_q;
  assign fetch_valid = fv_q;
  assign slot0_valid = fv_q & ~odd_q;
  assign flush       = (state_q == REDIRECT);
  assign halted      = (state_q == HALTED);

  a_flush_excl: assert property (@(posedge clk) !(flush && fetch_valid));
  a_halt_idle:  assert property (@(posedge clk) halted |-> !fetch_valid);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed scoreboard bench for branch_redirect_ctrl.
module tb_branch_redirect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       halt = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] pc_wb = '0;
  logic [7:0] pc_fetch;
  logic       fetch_valid, slot0_valid, flush, halted;

  branch_redirect_ctrl #(
    .PC_W(8),
    .FETCH_STEP(2),
    .FLUSH_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stall(stall),
    .halt(halt),
    .branch_taken(branch_taken),
    .pc_wb(pc_wb),
    .pc_fetch(pc_fetch),
    .fetch_valid(fetch_valid),
    .slot0_valid(slot0_valid),
    .flush(flush),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] pc;
    logic       fv;
    logic       s0;
    logic       fl;
    logic       hl;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares the expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      errors++;
      $display("FAIL stale_exp cyc=%0d expectation never matched (now cyc=%0d)", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (pc_fetch !== e.pc || fetch_valid !== e.fv || slot0_valid !== e.s0 ||
          flush !== e.fl || halted !== e.hl) begin
        errors++;
        $display("FAIL cyc%0d got pc=%h fv=%b s0=%b fl=%b hl=%b want pc=%h fv=%b s0=%b fl=%b hl=%b",
                 cyc, pc_fetch, fetch_valid, slot0_valid, flush, halted,
                 e.pc, e.fv, e.s0, e.fl, e.hl);
      end
    end
  end

  // One cycle: drive inputs after the edge, expect outputs after the next edge.
  task automatic drv(input logic rst, input logic st, input logic stl, input logic hlt,
                     input logic bt, input logic [7:0] wb,
                     input logic [7:0] epc, input logic efv, input logic es0,
                     input logic efl, input logic ehl);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; start = st; stall = stl; halt = hlt; branch_taken = bt; pc_wb = wb;
    e.cyc = cyc + 1; e.pc = epc; e.fv = efv; e.s0 = es0; e.fl = efl; e.hl = ehl;
    q.push_back(e);
  endtask

  task automatic idle_run(input logic [7:0] epc);
    drv(0, 0, 0, 0, 0, 8'h00, epc, 1, 1, 0, 0);
  endtask

  initial begin
    // reset and start: 0,2,4,...,0x10
    drv(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    drv(0, 0, 1, 1, 1, 8'h55, 8'h00, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
    for (int p = 2; p <= 'h10; p += 2) idle_run(8'(p));

    // stall two cycles at 0x10, then refetch 0x10 and continue
    drv(0, 0, 1, 0, 0, 8'h00, 8'h10, 0, 0, 0, 0);
    drv(0, 0, 1, 0, 0, 8'h00, 8'h10, 0, 0, 0, 0);
    idle_run(8'h10);
    idle_run(8'h12);
    for (int p = 'h14; p <= 'h20; p += 2) idle_run(8'(p));

    // odd target 0x41 from 0x20; stray take/stall/halt in the flush are ignored
    drv(0, 0, 0, 0, 1, 8'h41, 8'h40, 0, 0, 1, 0);
    drv(0, 0, 1, 1, 1, 8'h99, 8'h40, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 8'h00, 8'h40, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 8'h00, 8'h40, 1, 0, 0, 0);
    idle_run(8'h42);

    // take, halt and stall together: redirect wins
    drv(0, 0, 1, 1, 1, 8'h08, 8'h08, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 8'h00, 8'h08, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 8'h00, 8'h08, 0, 0, 1, 0);
    idle_run(8'h08);
    for (int p = 'h0A; p <= 'hFE; p += 2) idle_run(8'(p));
    idle_run(8'h00);

    // halt, then start is ignored
    drv(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    drv(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    drv(0, 1, 0, 0, 1, 8'h20, 8'h00, 0, 0, 0, 1);

    // reset out of HALTED, restart, then reset during the second flush cycle
    drv(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
    idle_run(8'h02);
    drv(0, 0, 0, 0, 1, 8'h31, 8'h30, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 8'h00, 8'h30, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    drv(0, 0, 1, 1, 1, 8'h44, 8'h00, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
